// File: rtl/input_debounce.sv
// Per-bit synchroniser plus stable-count debounce filter for asynchronous board inputs.
// Produces clean levels and registered one-cycle rise/fall pulses per bit.
module input_debounce #(
    parameter int N           = 5,
    parameter int CNT_MAX     = 1_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] raw_in,
    output logic [N-1:0] db_out,
    output logic [N-1:0] rise_pulse,
    output logic [N-1:0] fall_pulse
);

    localparam int             CW       = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(CNT_MAX - 1);

    logic [SYNC_STAGES-1:0][N-1:0] sync_q;
    logic [N-1:0]                  s;

    // NOTE: raw_in feeds the first flop directly; any gate in front of it could glitch on async edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= raw_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    for (genvar i = 0; i < N; i++) begin : g_bit
        logic [CW-1:0] cnt;
        logic          db_q;
        logic          rise_q;
        logic          fall_q;

        // Counter tracks consecutive cycles of disagreement; agreement discards it.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt    <= '0;
                db_q   <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                if (s[i] == db_q) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    cnt    <= '0;
                    db_q   <= s[i];
                    rise_q <= s[i];
                    fall_q <= ~s[i];
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign db_out[i]     = db_q;
        assign rise_pulse[i] = rise_q;
        assign fall_pulse[i] = fall_q;
    end

endmodule

// File: tb/tb_input_debounce.sv
// Self-checking bench for input_debounce: a window-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_input_debounce;

    localparam int N           = 5;
    localparam int CNT_MAX     = 4;
    localparam int SYNC_STAGES = 2;

    logic         clk;
    logic         reset;
    logic [N-1:0] raw_in;
    logic [N-1:0] db_out;
    logic [N-1:0] rise_pulse;
    logic [N-1:0] fall_pulse;

    int n_checks = 0;
    int n_fails  = 0;

    input_debounce #(
        .N          (N),
        .CNT_MAX    (CNT_MAX),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .raw_in    (raw_in),
        .db_out    (db_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: the synchronised value seen before edge e is raw_in sampled SYNC_STAGES
    // edges earlier; a bit flips when the last CNT_MAX such values since its previous flip all differ.
    logic [N-1:0] raw_hist[$];
    logic [N-1:0] s_hist[$];
    logic [N-1:0] exp_db   = '0;
    logic [N-1:0] exp_rise = '0;
    logic [N-1:0] exp_fall = '0;
    int           last_flip[N] = '{default: -1};

    always @(posedge reset) begin
        raw_hist.delete();
        s_hist.delete();
        exp_db   = '0;
        exp_rise = '0;
        exp_fall = '0;
        for (int i = 0; i < N; i++) last_flip[i] = -1;
    end

    always @(posedge clk) begin : model_step
        int           e;
        logic [N-1:0] sb;
        bit           ok;
        if (!reset) begin
            e  = raw_hist.size();
            sb = (e >= SYNC_STAGES) ? raw_hist[e-SYNC_STAGES] : '0;
            raw_hist.push_back(raw_in);
            s_hist.push_back(sb);
            exp_rise = '0;
            exp_fall = '0;
            for (int i = 0; i < N; i++) begin
                if (e - last_flip[i] >= CNT_MAX) begin
                    ok = 1'b1;
                    for (int j = e - CNT_MAX + 1; j <= e; j++) begin
                        if (s_hist[j][i] == exp_db[i]) ok = 1'b0;
                    end
                    if (ok) begin
                        exp_db[i]    = ~exp_db[i];
                        exp_rise[i]  = exp_db[i];
                        exp_fall[i]  = ~exp_db[i];
                        last_flip[i] = e;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        check("model_db",   32'(db_out),     32'(exp_db));
        check("model_rise", 32'(rise_pulse), 32'(exp_rise));
        check("model_fall", 32'(fall_pulse), 32'(exp_fall));
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset with all inputs high, then release and wait out the full latency
        reset  = 1'b1;
        raw_in = '1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_db",   32'(db_out),     32'h00);
        check("reset_rise", 32'(rise_pulse), 32'h00);
        check("reset_fall", 32'(fall_pulse), 32'h00);
        @(negedge clk) reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("t1_before", 32'(db_out), 32'h00);
        @(posedge clk);
        #1;
        check("t1_db",   32'(db_out),     32'h1f);
        check("t1_rise", 32'(rise_pulse), 32'h1f);
        @(posedge clk);
        #1;
        check("t1_rise_end", 32'(rise_pulse), 32'h00);
        @(negedge clk) raw_in = '0;
        repeat (10) @(negedge clk);
        check("t1_clear", 32'(db_out), 32'h00);

        // 2: single bit rising edge
        raw_in[0] = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("t2_before", 32'(db_out), 32'h00);
        @(posedge clk);
        #1;
        check("t2_db",   32'(db_out),     32'h01);
        check("t2_rise", 32'(rise_pulse), 32'h01);
        check("t2_fall", 32'(fall_pulse), 32'h00);
        @(posedge clk);
        #1;
        check("t2_rise_end", 32'(rise_pulse), 32'h00);

        // 3: three-cycle glitch rejected, four-cycle pulse accepted and then released
        @(negedge clk) raw_in[1] = 1'b1;
        repeat (3) @(negedge clk);
        raw_in[1] = 1'b0;
        repeat (10) @(negedge clk);
        check("t3_glitch", 32'(db_out), 32'h01);
        raw_in[1] = 1'b1;
        repeat (4) @(negedge clk);
        raw_in[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("t3_db_up", 32'(db_out),     32'h03);
        check("t3_rise",  32'(rise_pulse), 32'h02);
        repeat (4) @(posedge clk);
        #1;
        check("t3_db_down", 32'(db_out),     32'h01);
        check("t3_fall",    32'(fall_pulse), 32'h02);

        // 4: opposite transitions on two bits in the same cycle
        @(negedge clk) raw_in[3] = 1'b1;
        repeat (10) @(negedge clk);
        check("t4_setup", 32'(db_out), 32'h09);
        raw_in[2] = 1'b1;
        raw_in[3] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("t4_before", 32'(db_out), 32'h09);
        @(posedge clk);
        #1;
        check("t4_db",   32'(db_out),     32'h05);
        check("t4_rise", 32'(rise_pulse), 32'h04);
        check("t4_fall", 32'(fall_pulse), 32'h08);
        @(posedge clk);
        #1;
        check("t4_pulse_end", 32'(rise_pulse | fall_pulse), 32'h00);

        // 5: async reset between edges while bit 4 is mid-count
        @(negedge clk) raw_in[4] = 1'b1;
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("t5_async_db",   32'(db_out),     32'h00);
        check("t5_async_rise", 32'(rise_pulse), 32'h00);
        check("t5_async_fall", 32'(fall_pulse), 32'h00);
        @(negedge clk);
        @(negedge clk) reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("t5_before", 32'(db_out), 32'h00);
        @(posedge clk);
        #1;
        check("t5_db",   32'(db_out),     32'h15);
        check("t5_rise", 32'(rise_pulse), 32'h15);

        // 6: fast toggling on bit 4 is ignored, then a steady low is accepted
        @(negedge clk);
        for (int t = 0; t < 50; t++) begin
            raw_in[4] = ~raw_in[4];
            repeat (2) @(negedge clk);
        end
        check("t6_hold", 32'(db_out), 32'h15);
        raw_in[4] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("t6_before", 32'(db_out), 32'h15);
        @(posedge clk);
        #1;
        check("t6_db",   32'(db_out),     32'h05);
        check("t6_fall", 32'(fall_pulse), 32'h10);
        check("t6_rise", 32'(rise_pulse), 32'h00);
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
